// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash read responder: 0x03 read with one-byte prefetch, 0xAB wake-up.
// Inputs are synchronised in CLK_SYNC_STAGES flops; there is no backpressure, rd_data must arrive one cycle after rd_en.
module spi_flash_responder #(
    parameter int CLK_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_cs,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        rd_en,
    output logic [23:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        awake,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

    state_t state, state_nxt;

    logic [CLK_SYNC_STAGES-1:0] cs_pipe, sclk_pipe, mosi_pipe;
    logic cs_s, sclk_s, mosi_s;
    logic cs_q, sclk_q;
    logic cs_fall, sclk_rise, sclk_fall;

    logic [22:0] sr;
    logic [4:0]  bit_cnt;
    logic [7:0]  cmd_byte;
    logic [7:0]  shreg;
    logic [7:0]  pf_buf;
    logic [2:0]  bit_idx;
    logic        rd_pend;
    logic        first_load;
    logic        skip_fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_pipe   <= '1;
            sclk_pipe <= '0;
            mosi_pipe <= '0;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
        end else begin
            cs_pipe   <= {cs_pipe[CLK_SYNC_STAGES-2:0], spi_cs};
            sclk_pipe <= {sclk_pipe[CLK_SYNC_STAGES-2:0], spi_sclk};
            mosi_pipe <= {mosi_pipe[CLK_SYNC_STAGES-2:0], spi_mosi};
            cs_q      <= cs_s;
            sclk_q    <= sclk_s;
        end
    end

    assign cs_s      = cs_pipe[CLK_SYNC_STAGES-1];
    assign sclk_s    = sclk_pipe[CLK_SYNC_STAGES-1];
    assign mosi_s    = mosi_pipe[CLK_SYNC_STAGES-1];
    assign cs_fall   = ~cs_s & cs_q;
    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign cmd_byte  = {sr[6:0], mosi_s};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = CMD;
            CMD:     if (sclk_rise && bit_cnt == 5'd7)
                         state_nxt = (cmd_byte == 8'h03) ? ADDR : IGNORE;
            ADDR:    if (sclk_rise && bit_cnt == 5'd23) state_nxt = DATA;
            DATA:    state_nxt = DATA;
            IGNORE:  state_nxt = IGNORE;
            default: state_nxt = IDLE;
        endcase
        // Chip-select release wins over everything, so partial transfers never issue reads.
        if (state != IDLE && cs_s) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr         <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            pf_buf     <= '0;
            bit_idx    <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            rd_pend    <= 1'b0;
            first_load <= 1'b0;
            skip_fall  <= 1'b0;
            awake      <= 1'b0;
        end else begin
            rd_en   <= 1'b0;
            rd_pend <= rd_en;
            if (state == IDLE) bit_cnt <= '0;
            if ((state == CMD || state == ADDR) && sclk_rise) begin
                sr      <= {sr[21:0], mosi_s};
                bit_cnt <= (state == CMD && bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
            end
            if (state == CMD && state_nxt == IGNORE && cmd_byte == 8'hAB) awake <= 1'b1;
            if (state == ADDR && state_nxt == DATA) begin
                rd_en      <= 1'b1;
                rd_addr    <= {sr, mosi_s};
                first_load <= 1'b1;
                skip_fall  <= 1'b1;
            end
            if (state == DATA && state_nxt == DATA) begin
                if (rd_pend) begin
                    if (first_load) begin
                        shreg      <= rd_data;
                        bit_idx    <= '0;
                        first_load <= 1'b0;
                        rd_en      <= 1'b1;
                        rd_addr    <= rd_addr + 24'd1;
                    end else begin
                        pf_buf <= rd_data;
                    end
                end
                // The falling edge right after the last address bit precedes data bit 7; it must not shift.
                if (sclk_fall) begin
                    if (skip_fall) begin
                        skip_fall <= 1'b0;
                    end else if (bit_idx == 3'd7) begin
                        shreg   <= pf_buf;
                        bit_idx <= '0;
                        rd_en   <= 1'b1;
                        rd_addr <= rd_addr + 24'd1;
                    end else begin
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
            end
        end
    end

    assign spi_miso = (state == DATA) ? shreg[7] : 1'b0;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: expected read addresses and data bytes are queued at stimulus time.
module tb_spi_flash_responder;

    localparam int STAGES = 2;
    localparam int HALF   = 40;

    logic        clk;
    logic        reset;
    logic        spi_cs;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        rd_en;
    logic [23:0] rd_addr;
    logic [7:0]  rd_data;
    logic        awake;
    logic        busy;

    int checks;
    int errors;

    logic [23:0] exp_addr[$];
    logic [7:0]  exp_data[$];

    spi_flash_responder #(.CLK_SYNC_STAGES(STAGES)) dut (
        .clk      (clk),
        .reset    (reset),
        .spi_cs   (spi_cs),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .awake    (awake),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_val(input logic [23:0] a);
        if (a == 24'h010000) return 8'hA5;
        if (a == 24'h010001) return 8'h3C;
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    // Backing store: data is valid only during the cycle after rd_en.
    logic        pend_tb;
    logic [23:0] pend_addr;
    initial begin
        pend_tb   = 1'b0;
        pend_addr = '0;
        forever begin
            @(posedge clk);
            #2;
            rd_data   = pend_tb ? mem_val(pend_addr) : 8'hEE;
            pend_tb   = rd_en;
            pend_addr = rd_addr;
        end
    end

    // Read-request monitor: every rd_en must match the next queued address.
    logic prev_rd_en;
    initial begin
        prev_rd_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rd_en) begin
                check("rd_en_gap", {31'b0, prev_rd_en}, 0);
                if (exp_addr.size() == 0) check("rd_en_unexpected", {31'b0, rd_en}, 0);
                else check("rd_addr", {8'b0, rd_addr}, {8'b0, exp_addr.pop_front()});
            end
            prev_rd_en = rd_en;
        end
    end

    task automatic spi_bit(input logic b, input logic end_cs, output logic o);
        spi_mosi = b;
        #(HALF);
        spi_sclk = 1'b1;
        o = spi_miso;
        #(HALF);
        spi_sclk = 1'b0;
        if (end_cs) spi_cs = 1'b1;
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input logic last, output logic [7:0] rx);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], last && (i == 0), b);
            rx[i] = b;
        end
    endtask

    task automatic cs_start();
        spi_cs = 1'b0;
        #(2 * HALF);
    endtask

    task automatic do_read(input logic [23:0] a, input int n);
        logic [7:0] rx;
        for (int k = 0; k <= n; k++) exp_addr.push_back(a + 24'(k));
        for (int k = 0; k < n; k++) exp_data.push_back(mem_val(a + 24'(k)));
        cs_start();
        spi_xfer(8'h03, 1'b0, rx);
        check("cmd_miso", {24'b0, rx}, 0);
        spi_xfer(a[23:16], 1'b0, rx);
        spi_xfer(a[15:8], 1'b0, rx);
        spi_xfer(a[7:0], 1'b0, rx);
        for (int k = 0; k < n; k++) begin
            spi_xfer(8'h00, k == n - 1, rx);
            check("rd_byte", {24'b0, rx}, {24'b0, exp_data.pop_front()});
        end
        #200;
        check("busy_after_read", {31'b0, busy}, 0);
        check("rd_outstanding", exp_addr.size(), 0);
    endtask

    logic [7:0] rx_b;
    logic       bit_o;

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        spi_cs   = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        rd_data  = 8'h00;
        #23;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_rd_en", {31'b0, rd_en}, 0);
        check("rst_rd_addr", {8'b0, rd_addr}, 0);
        check("rst_awake", {31'b0, awake}, 0);
        check("rst_miso", {31'b0, spi_miso}, 0);
        #7;
        reset = 1'b0;
        #100;

        // Chip-select pulse with no clocks.
        spi_cs = 1'b0;
        #200;
        check("cs_pulse_busy_low", {31'b0, busy}, 1);
        spi_cs = 1'b1;
        #100;
        check("cs_pulse_busy", {31'b0, busy}, 0);
        check("cs_pulse_awake", {31'b0, awake}, 0);

        // Wake-up.
        cs_start();
        spi_xfer(8'hAB, 1'b1, rx_b);
        check("wake_miso", {24'b0, rx_b}, 0);
        #100;
        check("wake_awake", {31'b0, awake}, 1);
        check("wake_busy", {31'b0, busy}, 0);

        // Two-byte read and address wrap.
        do_read(24'h010000, 2);
        do_read(24'hFFFFFF, 2);

        // Abort after 12 address bits, then a normal read.
        cs_start();
        spi_xfer(8'h03, 1'b0, rx_b);
        for (int i = 0; i < 12; i++) spi_bit(i[0], 1'b0, bit_o);
        check("abort_busy_before", {31'b0, busy}, 1);
        spi_cs = 1'b1;
        repeat (STAGES + 1) @(posedge clk);
        #1;
        check("abort_busy", {31'b0, busy}, 0);
        #100;
        do_read(24'h123456, 1);

        // Unknown command followed by 32 clocks.
        cs_start();
        spi_xfer(8'h9F, 1'b0, rx_b);
        for (int k = 0; k < 4; k++) begin
            spi_xfer(8'hFF, k == 3, rx_b);
            check("unk_miso", {24'b0, rx_b}, 0);
        end
        #100;
        check("unk_awake", {31'b0, awake}, 1);
        check("unk_busy", {31'b0, busy}, 0);

        // Reset in the middle of data byte 3.
        for (int k = 0; k < 4; k++) exp_addr.push_back(24'h000200 + 24'(k));
        cs_start();
        spi_xfer(8'h03, 1'b0, rx_b);
        spi_xfer(8'h00, 1'b0, rx_b);
        spi_xfer(8'h02, 1'b0, rx_b);
        spi_xfer(8'h00, 1'b0, rx_b);
        spi_xfer(8'h00, 1'b0, rx_b);
        check("pre_rst_b1", {24'b0, rx_b}, {24'b0, mem_val(24'h000200)});
        spi_xfer(8'h00, 1'b0, rx_b);
        check("pre_rst_b2", {24'b0, rx_b}, {24'b0, mem_val(24'h000201)});
        for (int i = 0; i < 4; i++) spi_bit(1'b0, 1'b0, bit_o);
        check("pre_rst_busy", {31'b0, busy}, 1);
        #10;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'b0, busy}, 0);
        check("mid_rst_rd_en", {31'b0, rd_en}, 0);
        check("mid_rst_rd_addr", {8'b0, rd_addr}, 0);
        check("mid_rst_awake", {31'b0, awake}, 0);
        check("mid_rst_miso", {31'b0, spi_miso}, 0);
        check("mid_rst_outstanding", exp_addr.size(), 0);
        spi_cs = 1'b1;
        #29;
        reset = 1'b0;
        #100;
        check("post_rst_busy", {31'b0, busy}, 0);
        do_read(24'h000010, 2);
        check("post_rst_awake", {31'b0, awake}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 SHALL have parameter CLK_SYNC_STAGES, default 2, giving the synchronizer depth on spi_cs, spi_sclk and spi_mosi (legal range 2..3).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock for all logic.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port spi_cs, input, 1 bit: chip select, active low.
REQ-005 SHALL have port spi_sclk, input, 1 bit: SPI clock from the initiator, mode 0.
REQ-006 SHALL have port spi_mosi, input, 1 bit: initiator-to-responder data, MSB first.
REQ-007 SHALL have port spi_miso, output, 1 bit: responder-to-initiator data, MSB first.
REQ-008 SHALL have port rd_en, output, 1 bit: one-cycle byte-read strobe to the backing store.
REQ-009 SHALL have port rd_addr, output, 24 bits: byte address for rd_en.
REQ-010 SHALL have port rd_data, input, 8 bits: store data, valid exactly one clk cycle after rd_en.
REQ-011 SHALL have port awake, output, 1 bit: high once a release-power-down command (0xAB) has completed.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 SHALL pass spi_cs, spi_sclk and spi_mosi through CLK_SYNC_STAGES flops; all decisions use the synchronized values only.
REQ-014 SHALL detect an SCLK rising edge as synchronized sclk going 0->1 between consecutive clk cycles, and a falling edge as 1->0; correct operation requires a clk frequency of at least 4x the SCLK frequency.
REQ-015 SHALL implement states IDLE, CMD, ADDR, DATA and IGNORE.
REQ-016 IDLE: on synchronized spi_cs falling, SHALL enter CMD with the bit counter at 0.
REQ-017 CMD: SHALL shift in mosi on each rising edge; after the 8th bit it SHALL decode the byte: 0x03 -> ADDR, 0xAB -> set awake and go to IGNORE, any other value -> IGNORE.
REQ-018 ADDR: SHALL shift in 24 bits on rising edges; on the clk cycle after the 24th rising edge it SHALL pulse rd_en with rd_addr equal to the received address, then enter DATA.
REQ-019 DATA: SHALL load rd_data into the output shift register in the clk cycle after rd_en, and SHALL pulse rd_en for address+1 in that same cycle (one-byte prefetch).
REQ-020 DATA: spi_miso SHALL present bit 7 of the loaded byte immediately after loading, and SHALL shift to the next bit on each SCLK falling edge.
REQ-021 DATA: after the 8th falling edge of a byte, SHALL load the prefetched byte and issue the next prefetch; the address SHALL increment modulo 2^24 (0xFFFFFF wraps to 0x000000).
REQ-022 IGNORE: SHALL ignore SCLK and MOSI until spi_cs rises.
REQ-023 SHALL return to IDLE within one clk cycle of synchronized spi_cs rising, from any state and at any bit position, discarding partial command/address bits without issuing rd_en.
REQ-024 spi_miso SHALL be 0 in every state except DATA.
REQ-025 rd_en SHALL never be high for more than one consecutive cycle and SHALL be low in IDLE, CMD and IGNORE.
REQ-026 awake SHALL remain set until reset; repeated 0xAB commands have no further effect.
REQ-027 A spi_cs low pulse with no SCLK edges SHALL return to IDLE without changing awake.

Reset
REQ-028 While reset is high, all state SHALL be cleared asynchronously: state=IDLE, spi_miso=0, rd_en=0, rd_addr=0, awake=0, busy=0, synchronizers=idle values (cs=1, sclk=0, mosi=0).
REQ-029 Reset asserted mid-transaction SHALL abort it; after reset releases, the block SHALL wait for a fresh spi_cs falling edge before accepting a command.

Verification
REQ-030 Wake-up: cs low, shift in 0xAB, cs high -> awake=1, no rd_en pulse, miso=0 throughout.
REQ-031 Read: cmd 0x03, address 0x010000, store returns 0xA5 then 0x3C -> rd_addr 0x010000 then 0x010001, miso bits 1010_0101 then 0011_1100 sampled on rising edges.
REQ-032 Wrap: read at address 0xFFFFFF for 2 bytes -> rd_addr sequence 0xFFFFFF, 0x000000, 0x000001 (prefetch).
REQ-033 Abort: cs high after 12 address bits -> busy=0 within CLK_SYNC_STAGES+1 clk cycles, no rd_en, next 0x03 command works normally.
REQ-034 Unknown command 0x9F followed by 32 SCLKs -> no rd_en, miso=0, awake unchanged.
REQ-035 Reset pulse during DATA byte 3 -> all outputs at reset values immediately; a new read at 0x000010 returns the correct data.
